// File: rtl/cpu_pkg.sv
// Shared execute-stage types: opcode encoding, FSM states and datapath widths.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSB = 4'd10,
    OP_MUL   = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/cpu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle (XLEN/MUL_STEP cycles).
// done marks the cycle of the final step; product holds the low XLEN bits until the next start.
module cpu_mul_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int STEPS = XLEN / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS) + 1;

  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  partial;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  assign done    = run_q && (cnt_q == CNT_W'(STEPS - 1));
  assign product = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      cnt_d    = cnt_q + CNT_W'(1);
      run_d    = !done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/cpu_execute.sv
// Execute stage: 1-cycle ALU, optional iterative MUL (CPU_EXECUTE_MUL_EN, 32/MUL_STEP+1 cycles).
// Registered output with valid/ready; in_ready drops while the result is stalled or a MUL runs.
module cpu_execute #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [4:0]      addrw_in,
  input  logic            writeen_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      addrw,
  output logic            writeen,
  output logic            illegal,
  output logic            busy
);

  import cpu_pkg::*;

  if (XLEN != 32) begin : g_bad_xlen
    $error("cpu_execute: only XLEN=32 is supported");
  end
  if (MUL_STEP != 1 && MUL_STEP != 2 && MUL_STEP != 4) begin : g_bad_step
    $error("cpu_execute: MUL_STEP must be 1, 2 or 4");
  end

  logic [XLEN-1:0] op_b, alu_res;
  logic            alu_ill;
  logic            out_free, accept, ready_st;

  logic            ld_vld, ld_raw_we, ld_ill;
  logic [XLEN-1:0] ld_res;
  logic [4:0]      ld_addr;

  logic            vld_q, vld_d, we_q, we_d, ill_q, ill_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      addr_q, addr_d;

  assign op_b     = use_imm ? imm : rd2;
  assign out_free = !vld_q || out_ready;
  assign in_ready = rst_n && ready_st && out_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:   alu_res = rd1 + op_b;
      OP_SUB:   alu_res = rd1 - op_b;
      OP_AND:   alu_res = rd1 & op_b;
      OP_OR:    alu_res = rd1 | op_b;
      OP_XOR:   alu_res = rd1 ^ op_b;
      OP_SLL:   alu_res = rd1 << op_b[4:0];
      OP_SRL:   alu_res = rd1 >> op_b[4:0];
      OP_SRA:   alu_res = $unsigned($signed(rd1) >>> op_b[4:0]);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(rd1) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (rd1 < op_b)};
      OP_PASSB: alu_res = op_b;
      // MUL takes the multiplier path when compiled in; otherwise it lands here as illegal
      default:  alu_ill = 1'b1;
    endcase
  end

`ifdef CPU_EXECUTE_MUL_EN
  exec_state_t     state_q, state_d;
  logic            mul_start, mul_done;
  logic [XLEN-1:0] mul_prod;
  logic [4:0]      maddr_q, maddr_d;
  logic            mwe_q, mwe_d;

  cpu_mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (rd1),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign ready_st = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    maddr_d   = maddr_q;
    mwe_d     = mwe_q;
    ld_vld    = 1'b0;
    ld_res    = alu_res;
    ld_addr   = addrw_in;
    ld_raw_we = writeen_in;
    ld_ill    = alu_ill;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_op(op)) begin
            mul_start = 1'b1;
            maddr_d   = addrw_in;
            mwe_d     = writeen_in;
            state_d   = ST_MUL;
          end else begin
            ld_vld = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_free) begin
          ld_vld    = 1'b1;
          ld_res    = mul_prod;
          ld_addr   = maddr_q;
          ld_raw_we = mwe_q;
          ld_ill    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      maddr_q <= '0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
      mwe_q   <= mwe_d;
    end
  end
`else
  assign ready_st  = 1'b1;
  assign busy      = 1'b0;
  assign ld_vld    = accept;
  assign ld_res    = alu_res;
  assign ld_addr   = addrw_in;
  assign ld_raw_we = writeen_in;
  assign ld_ill    = alu_ill;
`endif

  // Illegal results never write, and x0 is never written.
  always_comb begin
    vld_d  = ld_vld || (vld_q && !out_ready);
    res_d  = res_q;
    addr_d = addr_q;
    we_d   = we_q;
    ill_d  = ill_q;
    if (ld_vld) begin
      res_d  = ld_ill ? '0 : ld_res;
      addr_d = ld_addr;
      we_d   = ld_raw_we && (ld_addr != 5'd0) && !ld_ill;
      ill_d  = ld_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      res_q  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      res_q  <= res_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      ill_q  <= ill_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign addrw     = addr_q;
  assign writeen   = we_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_cpu_execute.sv
// Self-checking bench for cpu_execute: directed vector table, corner sequences, randomized scoreboard.
module tb_cpu_execute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] rd1 = 32'd0, rd2 = 32'd0, imm = 32'd0;
  logic        use_imm = 1'b0;
  logic [4:0]  addrw_in = 5'd0;
  logic        writeen_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  addrw;
  logic        writeen, illegal, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_execute #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rd1        (rd1),
    .rd2        (rd2),
    .imm        (imm),
    .use_imm    (use_imm),
    .addrw_in   (addrw_in),
    .writeen_in (writeen_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .addrw      (addrw),
    .writeen    (writeen),
    .illegal    (illegal),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        ui;
    logic [4:0]  ad;
    logic        we;
    logic [31:0] xres;
    logic        xwe;
    logic        xill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  ad;
    logic        we;
    logic        ill;
  } exp_t;

  vec_t vt[16];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic ui, input logic [4:0] ad, input logic we);
    op = o; rd1 = a; rd2 = b; imm = im; use_imm = ui; addrw_in = ad; writeen_in = we;
  endtask

  // Reference behaviour from the opcode rules, in plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] ad, input logic we);
    exp_t e;
    int unsigned sh;
    int sa, sb;
    longint unsigned p;
    sh = b % 32;
    sa = a;
    sb = b;
    e.res = 32'd0;
    e.ill = 1'b0;
    case (o)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: begin p = {32'd0, a} * (64'd1 << sh); e.res = p[31:0]; end
      4'd6: e.res = a / (32'd1 << sh);
      4'd7: e.res = (sa < 0) ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.res = b;
`ifdef CPU_EXECUTE_MUL_EN
      4'd11: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
`endif
      default: e.ill = 1'b1;
    endcase
    e.ad = ad;
    e.we = we && (ad != 5'd0) && !e.ill;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Call #1 after a negedge: retire an output handshake against the scoreboard.
  task automatic sb_out();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_unexpected_output: got result %h with empty scoreboard", result);
      end else begin
        e = sbq.pop_front();
        chk("rnd_result", result, e.res);
        chk("rnd_addrw", {27'd0, addrw}, {27'd0, e.ad});
        chk("rnd_writeen", {31'd0, writeen}, {31'd0, e.we});
        chk("rnd_illegal", {31'd0, illegal}, {31'd0, e.ill});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int guard;
    int n_out;
    logic spurious;
    exp_t e;

    vt[0]  = '{4'd0,  32'd5,          32'd7,          32'd0,          1'b0, 5'd3,  1'b1, 32'd12,         1'b1, 1'b0};
    vt[1]  = '{4'd1,  32'd5,          32'd7,          32'd0,          1'b0, 5'd4,  1'b1, 32'hFFFF_FFFE,  1'b1, 1'b0};
    vt[2]  = '{4'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          1'b0, 5'd5,  1'b1, 32'h00F0_00F0,  1'b1, 1'b0};
    vt[3]  = '{4'd3,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          1'b0, 5'd6,  1'b1, 32'hFFF0_FFF0,  1'b1, 1'b0};
    vt[4]  = '{4'd4,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,          1'b0, 5'd7,  1'b1, 32'hFF00_FF00,  1'b1, 1'b0};
    vt[5]  = '{4'd5,  32'd1,          32'd0,          32'h0000_003F,  1'b1, 5'd8,  1'b1, 32'h8000_0000,  1'b1, 1'b0};
    vt[6]  = '{4'd6,  32'h8000_0000,  32'd4,          32'd0,          1'b0, 5'd9,  1'b1, 32'h0800_0000,  1'b1, 1'b0};
    vt[7]  = '{4'd7,  32'h8000_0000,  32'd0,          32'd4,          1'b1, 5'd10, 1'b1, 32'hF800_0000,  1'b1, 1'b0};
    vt[8]  = '{4'd8,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 5'd11, 1'b1, 32'd0,          1'b1, 1'b0};
    vt[9]  = '{4'd9,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 5'd12, 1'b1, 32'd1,          1'b1, 1'b0};
    vt[10] = '{4'd10, 32'd99,         32'd123,        32'hDEAD_BEEF,  1'b1, 5'd31, 1'b1, 32'hDEAD_BEEF,  1'b1, 1'b0};
    vt[11] = '{4'd0,  32'd1,          32'd1,          32'd0,          1'b0, 5'd0,  1'b1, 32'd2,          1'b0, 1'b0};
    vt[12] = '{4'd13, 32'd5,          32'd7,          32'd0,          1'b0, 5'd3,  1'b1, 32'd0,          1'b0, 1'b1};
    vt[13] = '{4'd15, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 5'd2,  1'b1, 32'd0,          1'b0, 1'b1};
    vt[14] = '{4'd0,  32'd3,          32'd4,          32'd0,          1'b0, 5'd6,  1'b0, 32'd7,          1'b0, 1'b0};
    vt[15] = '{4'd0,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 5'd1,  1'b1, 32'd0,          1'b1, 1'b0};

    // Reset values
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_addrw", {27'd0, addrw}, 32'd0);
    chk("rst_writeen", {31'd0, writeen}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].ui, vt[i].ad, vt[i].we);
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1 chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), result, vt[i].xres);
      chk($sformatf("vec%0d_addrw", i), {27'd0, addrw}, {27'd0, vt[i].ad});
      chk($sformatf("vec%0d_writeen", i), {31'd0, writeen}, {31'd0, vt[i].xwe});
      chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vt[i].xill});
    end

    // Back-pressure: two ADDs with the output stalled
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd4, 1'b1);
    in_valid = 1'b1;
    #1 chk("bp_first_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_result", result, 32'd3);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_result", result, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_second_result", result, 32'd30);
    chk("bp_second_addrw", {27'd0, addrw}, 32'd5);
    @(negedge clk);
    #1 chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // MUL 0xFFFFFFFF x 3 with the output stalled at completion
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'd11, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 5'd7, 1'b1);
    in_valid = 1'b1;
    #1 chk("mul_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef CPU_EXECUTE_MUL_EN
    cnt = 0;
    guard = 0;
    #1;
    while (busy && guard < 200) begin
      if (cnt == 5) chk("mul_in_ready_running", {31'd0, in_ready}, 32'd0);
      cnt++;
      guard++;
      @(negedge clk);
      #1;
    end
    chk("mul_busy_cycles", cnt, 33);
    chk("mul_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_result", result, 32'hFFFF_FFFD);
    chk("mul_addrw", {27'd0, addrw}, 32'd7);
    chk("mul_writeen", {31'd0, writeen}, 32'd1);
    chk("mul_illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("mul_held_result", result, 32'hFFFF_FFFD);
    chk("mul_held_in_ready", {31'd0, in_ready}, 32'd0);
`else
    #1;
    chk("mul_off_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_off_illegal", {31'd0, illegal}, 32'd1);
    chk("mul_off_result", result, 32'd0);
    chk("mul_off_writeen", {31'd0, writeen}, 32'd0);
    chk("mul_off_busy", {31'd0, busy}, 32'd0);
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("mul_drained", {31'd0, out_valid}, 32'd0);

    // Reset ten cycles into a MUL
    @(negedge clk);
    out_ready = 1'b0;
    drive(4'd11, 32'd123, 32'd456, 32'd0, 1'b0, 5'd9, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1;
`ifdef CPU_EXECUTE_MUL_EN
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
`else
    chk("abort_held_before", {31'd0, out_valid}, 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_addrw", {27'd0, addrw}, 32'd0);
    chk("abort_writeen", {31'd0, writeen}, 32'd0);
    chk("abort_illegal", {31'd0, illegal}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd2, 1'b1);
    in_valid = 1'b1;
    #1 chk("abort_add_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("abort_add_valid", {31'd0, out_valid}, 32'd1);
    chk("abort_add_result", result, 32'd2);
    chk("abort_add_writeen", {31'd0, writeen}, 32'd1);
    spurious = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (out_valid || busy) spurious = 1'b1;
    end
    chk("abort_no_stale_product", {31'd0, spurious}, 32'd0);

    // Randomized traffic against the reference model
    n_out = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      if (op == 4'd11 && $urandom_range(0, 7) != 0) op = 4'd0;
      rd1 = pick();
      rd2 = pick();
      imm = pick();
      use_imm = 1'($urandom_range(0, 1));
      addrw_in = 5'($urandom_range(0, 31));
      writeen_in = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) n_out++;
      sb_out();
      if (in_valid && in_ready) begin
        e = model(op, rd1, use_imm ? imm : rd2, addrw_in, writeen_in);
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    #1;
    while ((sbq.size() != 0 || out_valid || busy) && guard < 200) begin
      sb_out();
      @(negedge clk);
      #1;
      guard++;
    end
    chk("rnd_scoreboard_empty", sbq.size(), 32'd0);
    chk("rnd_enough_traffic", {31'd0, (n_out > 500)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
